// File: rtl/permutation_unrolled.sv
// Ascon-p permutation with UNROLL combinational rounds per clock and a start/done/error handshake.
// The 320-bit state is five 64-bit words, with x0 in element 0 (bits 63:0).
package ascon_pack;
   typedef logic [4:0][63:0] type_state;
endpackage

module permutation_unrolled
   import ascon_pack::*;
#(
   parameter int UNROLL = 1
) (
   input  logic       clock_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [3:0] nb_rounds_i,
   input  type_state  S_i,
   output logic       ready_o,
   output logic       done_o,
   output logic       error_o,
   output type_state  S_o
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 || UNROLL == 6)) begin : g_bad_unroll
      $error("permutation_unrolled: UNROLL must be 1, 2, 3, 4 or 6");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     fsm;
   logic [3:0] step_cnt;
   logic [3:0] n_lat;
   type_state  state_q;

   logic       running;
   logic       legal;
   logic       single_step;
   logic       last_step;
   logic [3:0] n_sel;
   logic [3:0] c_sel;
   logic [3:0] round_base;
   type_state  stage [UNROLL+1];

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // One full round: constant addition on x2, bitsliced 5-bit S-box, per-word linear diffusion.
   function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      type_state   o;
      x0 = s[0];
      x1 = s[1];
      x2 = s[2] ^ {56'd0, ~r, r};
      x3 = s[3];
      x4 = s[4];
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      o[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      o[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      o[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      o[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      o[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
      return o;
   endfunction

   // Outside RUN the chain works on the incoming request (N from the port, step 0).
   always_comb begin
      running     = (fsm == RUN);
      n_sel       = running ? n_lat : nb_rounds_i;
      c_sel       = running ? step_cnt : 4'd0;
      round_base  = 4'(12 - int'(n_sel) + int'(c_sel) * UNROLL);
      legal       = (nb_rounds_i == 4'd6 || nb_rounds_i == 4'd8 || nb_rounds_i == 4'd12)
                    && (int'(nb_rounds_i) % UNROLL == 0);
      single_step = (int'(nb_rounds_i) / UNROLL == 1);
      last_step   = (int'(step_cnt) == int'(n_lat) / UNROLL - 1);
   end

   assign stage[0] = running ? state_q : S_i;

   for (genvar j = 0; j < UNROLL; j++) begin : g_round
      assign stage[j+1] = ascon_round(stage[j], round_base + 4'(j));
   end

   always_ff @(posedge clock_i) begin
      if (rst_i) begin
         fsm      <= IDLE;
         ready_o  <= 1'b1;
         done_o   <= 1'b0;
         error_o  <= 1'b0;
         state_q  <= '0;
         step_cnt <= 4'd0;
         n_lat    <= 4'd0;
      end else begin
         done_o  <= 1'b0;
         error_o <= 1'b0;
         case (fsm)
            IDLE, DONE: begin
               if (start_i && legal) begin
                  n_lat    <= nb_rounds_i;
                  state_q  <= stage[UNROLL];
                  step_cnt <= 4'd1;
                  if (single_step) begin
                     fsm     <= DONE;
                     ready_o <= 1'b1;
                     done_o  <= 1'b1;
                  end else begin
                     fsm     <= RUN;
                     ready_o <= 1'b0;
                  end
               end else begin
                  error_o <= start_i;
                  fsm     <= IDLE;
                  ready_o <= 1'b1;
               end
            end
            RUN: begin
               state_q  <= stage[UNROLL];
               step_cnt <= step_cnt + 4'd1;
               if (last_step) begin
                  fsm     <= DONE;
                  ready_o <= 1'b1;
                  done_o  <= 1'b1;
               end
            end
            default: begin
               fsm     <= IDLE;
               ready_o <= 1'b1;
            end
         endcase
      end
   end

   assign S_o = state_q;

endmodule

// File: tb/tb_permutation_unrolled.sv
// Self-checking bench: five instances (UNROLL 1,2,3,4,6) checked against a table-driven Ascon-p model.
module tb_permutation_unrolled;
   import ascon_pack::*;

   localparam int NI = 5;
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start [NI];
   logic [3:0] nb    [NI];
   type_state  s_in  [NI];
   logic       ready [NI];
   logic       done  [NI];
   logic       err   [NI];
   type_state  s_out [NI];
   type_state  last_exp [NI];

   int checks   = 0;
   int failures = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      permutation_unrolled #(.UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 3 : g == 3 ? 4 : 6)) dut (
         .clock_i     (clk),
         .rst_i       (rst),
         .start_i     (start[g]),
         .nb_rounds_i (nb[g]),
         .S_i         (s_in[g]),
         .ready_o     (ready[g]),
         .done_o      (done[g]),
         .error_o     (err[g]),
         .S_o         (s_out[g])
      );
   end

   function automatic int unr(input int g);
      case (g)
         0:       return 1;
         1:       return 2;
         2:       return 3;
         3:       return 4;
         default: return 6;
      endcase
   endfunction

   function automatic logic [63:0] rot(input logic [63:0] v, input int n);
      logic [127:0] d;
      d = {v, v} >> n;
      return d[63:0];
   endfunction

   // Reference Ascon-p: rounds 12-n..11, S-box applied column by column through the lookup table.
   function automatic type_state ref_perm(input type_state s, input int n);
      logic [63:0] x [5];
      logic [4:0]  col;
      type_state   o;
      for (int i = 0; i < 5; i++) x[i] = s[i];
      for (int r = 12 - n; r < 12; r++) begin
         x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
         for (int b = 0; b < 64; b++) begin
            col = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
            x[0][b] = col[4];
            x[1][b] = col[3];
            x[2][b] = col[2];
            x[3][b] = col[1];
            x[4][b] = col[0];
         end
         x[0] = x[0] ^ rot(x[0], 19) ^ rot(x[0], 28);
         x[1] = x[1] ^ rot(x[1], 61) ^ rot(x[1], 39);
         x[2] = x[2] ^ rot(x[2], 1)  ^ rot(x[2], 6);
         x[3] = x[3] ^ rot(x[3], 10) ^ rot(x[3], 17);
         x[4] = x[4] ^ rot(x[4], 7)  ^ rot(x[4], 41);
      end
      for (int i = 0; i < 5; i++) o[i] = x[i];
      return o;
   endfunction

   function automatic type_state rand_state();
      type_state o;
      for (int i = 0; i < 5; i++) o[i] = {$urandom, $urandom};
      return o;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int g = 0; g < NI; g++) begin
         start[g] = 1'b0;
         nb[g]    = 4'd0;
         s_in[g]  = '0;
         last_exp[g] = '0;
      end
      repeat (2) @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         checks++;
         if (ready[g] !== 1'b1 || done[g] !== 1'b0 || err[g] !== 1'b0 || s_out[g] !== '0) begin
            failures++;
            $display("[TB] FAIL reset u%0d: ready=%b done=%b error=%b S_o=%h, required 1 0 0 and zero",
                     unr(g), ready[g], done[g], err[g], s_out[g]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_permutation(input int g, input int n, input type_state s, input string tag);
      type_state exp_s;
      int        k;
      exp_s    = ref_perm(s, n);
      k        = n / unr(g);
      start[g] = 1'b1;
      nb[g]    = 4'(n);
      s_in[g]  = s;
      @(negedge clk);
      start[g] = 1'b0;
      s_in[g]  = rand_state();
      for (int i = 1; i <= k; i++) begin
         if (i > 1) @(negedge clk);
         checks++;
         if (done[g] !== (i == k) || ready[g] !== (i == k) || err[g] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s u%0d n%0d cycle%0d: done=%b ready=%b error=%b, required done=%b ready=%b error=0",
                     tag, unr(g), n, i, done[g], ready[g], err[g], (i == k), (i == k));
         end
      end
      checks++;
      if (s_out[g] !== exp_s) begin
         failures++;
         $display("[TB] FAIL %s u%0d n%0d state: S_o=%h required %h", tag, unr(g), n, s_out[g], exp_s);
      end
      @(negedge clk);
      checks++;
      if (done[g] !== 1'b0 || ready[g] !== 1'b1 || s_out[g] !== exp_s) begin
         failures++;
         $display("[TB] FAIL %s u%0d n%0d hold: done=%b ready=%b S_o=%h, required 0 1 %h",
                  tag, unr(g), n, done[g], ready[g], s_out[g], exp_s);
      end
      last_exp[g] = exp_s;
   endtask

   task automatic test_back_to_back(input int g);
      type_state s1, s2, e1, e2;
      int        k;
      s1 = rand_state();
      s2 = rand_state();
      e1 = ref_perm(s1, 12);
      e2 = ref_perm(s2, 12);
      k  = 12 / unr(g);
      start[g] = 1'b1;
      nb[g]    = 4'd12;
      s_in[g]  = s1;
      @(negedge clk);
      start[g] = 1'b0;
      repeat (k - 1) @(negedge clk);
      checks++;
      if (done[g] !== 1'b1 || s_out[g] !== e1) begin
         failures++;
         $display("[TB] FAIL b2b_first u%0d: done=%b S_o=%h, required 1 %h", unr(g), done[g], s_out[g], e1);
      end
      start[g] = 1'b1;
      s_in[g]  = s2;
      @(negedge clk);
      start[g] = 1'b0;
      for (int i = 1; i <= k; i++) begin
         if (i > 1) @(negedge clk);
         checks++;
         if (done[g] !== (i == k)) begin
            failures++;
            $display("[TB] FAIL b2b_second_timing u%0d cycle%0d: done=%b required %b", unr(g), i, done[g], (i == k));
         end
      end
      checks++;
      if (s_out[g] !== e2) begin
         failures++;
         $display("[TB] FAIL b2b_second_state u%0d: S_o=%h required %h", unr(g), s_out[g], e2);
      end
      @(negedge clk);
      last_exp[g] = e2;
   endtask

   task automatic test_illegal(input int g, input int n);
      start[g] = 1'b1;
      nb[g]    = 4'(n);
      s_in[g]  = rand_state();
      @(negedge clk);
      start[g] = 1'b0;
      checks++;
      if (err[g] !== 1'b1 || done[g] !== 1'b0 || ready[g] !== 1'b1 || s_out[g] !== last_exp[g]) begin
         failures++;
         $display("[TB] FAIL illegal u%0d n%0d: error=%b done=%b ready=%b S_o=%h, required 1 0 1 %h",
                  unr(g), n, err[g], done[g], ready[g], s_out[g], last_exp[g]);
      end
      @(negedge clk);
      checks++;
      if (err[g] !== 1'b0 || done[g] !== 1'b0 || ready[g] !== 1'b1 || s_out[g] !== last_exp[g]) begin
         failures++;
         $display("[TB] FAIL illegal_after u%0d n%0d: error=%b done=%b ready=%b, required 0 0 1",
                  unr(g), n, err[g], done[g], ready[g]);
      end
   endtask

   task automatic test_start_during_run();
      type_state s1, e1;
      s1 = rand_state();
      e1 = ref_perm(s1, 12);
      start[0] = 1'b1;
      nb[0]    = 4'd12;
      s_in[0]  = s1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      start[0] = 1'b1;
      nb[0]    = 4'd6;
      s_in[0]  = rand_state();
      @(negedge clk);
      start[0] = 1'b0;
      for (int i = 4; i <= 12; i++) begin
         if (i > 4) @(negedge clk);
         checks++;
         if (done[0] !== (i == 12) || ready[0] !== (i == 12) || err[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL run_ignore cycle%0d: done=%b ready=%b error=%b, required done=%b ready=%b error=0",
                     i, done[0], ready[0], err[0], (i == 12), (i == 12));
         end
      end
      checks++;
      if (s_out[0] !== e1) begin
         failures++;
         $display("[TB] FAIL run_ignore_state: S_o=%h required %h", s_out[0], e1);
      end
      @(negedge clk);
      last_exp[0] = e1;
   endtask

   task automatic test_reset_mid();
      int seen;
      start[0] = 1'b1;
      nb[0]    = 4'd12;
      s_in[0]  = rand_state();
      @(negedge clk);
      start[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int g = 0; g < NI; g++) last_exp[g] = '0;
      checks++;
      if (s_out[0] !== '0 || ready[0] !== 1'b1 || done[0] !== 1'b0 || err[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid: S_o=%h ready=%b done=%b error=%b, required zero 1 0 0",
                  s_out[0], ready[0], done[0], err[0]);
      end
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done[0] !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("[TB] FAIL reset_mid_no_done: done seen %0d times, required 0", seen);
      end
      test_permutation(0, 12, rand_state(), "after_reset");
   endtask

   task automatic test_reset_with_start();
      int seen;
      rst      = 1'b1;
      start[1] = 1'b1;
      nb[1]    = 4'd12;
      s_in[1]  = rand_state();
      @(negedge clk);
      rst      = 1'b0;
      start[1] = 1'b0;
      checks++;
      if (s_out[1] !== '0 || ready[1] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_start: S_o=%h ready=%b, required zero 1", s_out[1], ready[1]);
      end
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done[1] !== 1'b0 || ready[1] !== 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("[TB] FAIL reset_start_dropped: busy/done seen %0d cycles, required 0", seen);
      end
      for (int g = 0; g < NI; g++) last_exp[g] = '0;
   endtask

   initial begin
      int ns [3];
      ns = '{6, 8, 12};
      test_reset();
      test_permutation(0, 12, '0, "zero_n12");
      for (int g = 0; g < NI; g++) begin
         for (int i = 0; i < 3; i++) begin
            if (ns[i] % unr(g) == 0) test_permutation(g, ns[i], rand_state(), "random");
         end
      end
      test_back_to_back(0);
      test_back_to_back(2);
      test_back_to_back(4);
      test_illegal(0, 0);
      test_illegal(0, 7);
      test_illegal(0, 13);
      test_illegal(3, 6);
      test_illegal(4, 8);
      test_start_during_run();
      test_reset_mid();
      test_reset_with_start();
      test_permutation(2, 12, rand_state(), "final");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
